// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel button debouncer.
package debounce_pkg;

    localparam int unsigned CLK_HZ            = 32'd100_000_000;
    localparam int unsigned DEBOUNCE_MS       = 32'd10;
    localparam int unsigned DEF_STABLE_CYC    = (CLK_HZ / 32'd1000) * DEBOUNCE_MS;
    localparam int unsigned DEF_REPEAT_DELAY  = 32'd50_000_000;
    localparam int unsigned DEF_REPEAT_PERIOD = 32'd10_000_000;

    // Bits needed to encode values 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n < 32'd3) begin
            return 32'd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounced channel: 2-FF synchroniser, stability counter, press/release
// strobes and an optional auto-repeat strobe while the button is held.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYC    = DEF_STABLE_CYC,
    parameter int unsigned ACTIVE_LOW    = 32'd0,
    parameter int unsigned REPEAT_EN     = 32'd0,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int unsigned CW   = cnt_width(STABLE_CYC + 32'd1);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = cnt_width(RMAX + 32'd1);

    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 32'd1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 32'd1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 32'd1);
    localparam logic          IDLE_LVL = (ACTIVE_LOW != 32'd0) ? 1'b1 : 1'b0;
    localparam logic          REP_ON   = (REPEAT_EN != 32'd0) ? 1'b1 : 1'b0;

    logic          sync0_q, sync0_d;
    logic          sync1_q, sync1_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          first_q, first_d;
    logic          repeat_q, repeat_d;
    logic          s;
    logic          toggle;
    logic [RW-1:0] rpt_last;

    // Next-state logic for qualification, strobes and the repeat timer.
    always_comb begin
        sync0_d   = btn_i;
        sync1_d   = sync0_q;
        s         = sync1_q ^ IDLE_LVL;
        toggle    = 1'b0;
        cnt_d     = cnt_q;
        level_d   = level_q;

        if (s == level_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            toggle  = 1'b1;
            level_d = ~level_q;
            cnt_d   = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1'b1);
        end

        press_d   = toggle & ~level_q;
        release_d = toggle & level_q;

        // The first pulse waits REPEAT_DELAY, later ones REPEAT_PERIOD; the
        // timer reloads on each pulse and is held clear while released.
        rpt_last = first_q ? DLY_LAST : PER_LAST;
        if (!level_q || toggle) begin
            rcnt_d   = {RW{1'b0}};
            first_d  = 1'b1;
            repeat_d = 1'b0;
        end else if (rcnt_q == rpt_last) begin
            rcnt_d   = {RW{1'b0}};
            first_d  = 1'b0;
            repeat_d = REP_ON;
        end else begin
            rcnt_d   = rcnt_q + RW'(1'b1);
            first_d  = first_q;
            repeat_d = 1'b0;
        end
    end

    // Channel state registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync0_q   <= IDLE_LVL;
            sync1_q   <= IDLE_LVL;
            cnt_q     <= {CW{1'b0}};
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            rcnt_q    <= {RW{1'b0}};
            first_q   <= 1'b1;
            repeat_q  <= 1'b0;
        end else begin
            sync0_q   <= sync0_d;
            sync1_q   <= sync1_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            rcnt_q    <= rcnt_d;
            first_q   <= first_d;
            repeat_q  <= repeat_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/multi_debounce.sv
// N independent debounced button channels; the top only fans vectors in and out.
module multi_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned CH            = 32'd4,
    parameter int unsigned STABLE_CYC    = DEF_STABLE_CYC,
    parameter int unsigned ACTIVE_LOW    = 32'd0,
    parameter int unsigned REPEAT_EN     = 32'd0,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic          clk100_i,
    input  logic          rstn_i,
    input  logic [CH-1:0] btn_i,
    output logic [CH-1:0] level_o,
    output logic [CH-1:0] press_o,
    output logic [CH-1:0] release_o,
    output logic [CH-1:0] repeat_o
);

    for (genvar g = 0; g < int'(CH); g++) begin : g_ch
        debounce_ch #(
            .STABLE_CYC   (STABLE_CYC),
            .ACTIVE_LOW   (ACTIVE_LOW),
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk_i    (clk100_i),
            .rstn_i   (rstn_i),
            .btn_i    (btn_i[g]),
            .level_o  (level_o[g]),
            .press_o  (press_o[g]),
            .release_o(release_o[g]),
            .repeat_o (repeat_o[g])
        );
    end

endmodule

// File: tb/tb_multi_debounce.sv
// Scoreboard bench: an active-high and an active-low instance see complementary
// stimulus and must produce identical, hand-predicted output events.
module tb_multi_debounce;

    logic       clk;
    logic       rstn;
    logic [1:0] btn;
    logic [1:0] btn_n;
    logic [1:0] lvl0, prs0, rls0, rpt0;
    logic [1:0] lvl1, prs1, rls1, rpt1;
    int         cyc;
    int         n_cmp;
    int         n_bad;

    typedef struct {
        int         cyc;
        logic [7:0] out;
    } exp_t;

    exp_t q[$];

    assign btn_n = ~btn;

    multi_debounce #(
        .CH(2), .STABLE_CYC(4), .ACTIVE_LOW(0), .REPEAT_EN(1),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
    ) dut0 (
        .clk100_i(clk), .rstn_i(rstn), .btn_i(btn),
        .level_o(lvl0), .press_o(prs0), .release_o(rls0), .repeat_o(rpt0)
    );

    multi_debounce #(
        .CH(2), .STABLE_CYC(4), .ACTIVE_LOW(1), .REPEAT_EN(1),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
    ) dut1 (
        .clk100_i(clk), .rstn_i(rstn), .btn_i(btn_n),
        .level_o(lvl1), .press_o(prs1), .release_o(rls1), .repeat_o(rpt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output vector order: {level, press, release, repeat}.
    task automatic expect_at(input int at, input logic [1:0] l, input logic [1:0] p,
                             input logic [1:0] r, input logic [1:0] rp);
        exp_t e;
        e.cyc = at;
        e.out = {l, p, r, rp};
        q.push_back(e);
    endtask

    task automatic check_ev(input string name, input int got_cyc, input logic [7:0] got, input exp_t e);
        n_cmp++;
        if (got_cyc != e.cyc || got !== e.out) begin
            n_bad++;
            $display("FAIL %s: got cyc=%0d out=%b, expected cyc=%0d out=%b",
                     name, got_cyc, got, e.cyc, e.out);
        end
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if ({lvl0, prs0, rls0, rpt0, lvl1, prs1, rls1, rpt1} !== 16'h0000) begin
            n_bad++;
            $display("FAIL %s: got dut0=%b dut1=%b, expected all zero", name,
                     {lvl0, prs0, rls0, rpt0}, {lvl1, prs1, rls1, rpt1});
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: any strobe or level change on either instance is an event.
    initial begin
        logic [1:0] prev0;
        logic [1:0] prev1;
        exp_t       e;
        prev0 = 2'b00;
        prev1 = 2'b00;
        forever begin
            @(negedge clk);
            if ((|{prs0, rls0, rpt0, prs1, rls1, rpt1}) || lvl0 !== prev0 || lvl1 !== prev1) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: cyc=%0d dut0=%b dut1=%b, expected no event",
                             cyc, {lvl0, prs0, rls0, rpt0}, {lvl1, prs1, rls1, rpt1});
                end else begin
                    e = q.pop_front();
                    check_ev("event_dut0", cyc, {lvl0, prs0, rls0, rpt0}, e);
                    check_ev("event_dut1", cyc, {lvl1, prs1, rls1, rpt1}, e);
                end
            end
            prev0 = lvl0;
            prev1 = lvl1;
        end
    end

    initial begin
        int c;
        n_cmp = 0;
        n_bad = 0;
        rstn  = 1'b0;
        btn   = 2'b11;

        // Both buttons held through reset, then released from reset.
        step(3);
        check_zero("reset_outputs");
        rstn = 1'b1;
        c = cyc;
        expect_at(c + 6, 2'b11, 2'b11, 2'b00, 2'b00);
        step(8);
        btn = 2'b00;
        c = cyc;
        expect_at(c + 6, 2'b00, 2'b00, 2'b11, 2'b00);
        step(12);

        // Clean press on channel 0, held for three repeats, then released.
        btn = 2'b01;
        c = cyc;
        expect_at(c + 6,  2'b01, 2'b01, 2'b00, 2'b00);
        expect_at(c + 16, 2'b01, 2'b00, 2'b00, 2'b01);
        expect_at(c + 21, 2'b01, 2'b00, 2'b00, 2'b01);
        expect_at(c + 26, 2'b01, 2'b00, 2'b00, 2'b01);
        step(23);
        btn = 2'b00;
        c = cyc;
        expect_at(c + 6, 2'b00, 2'b00, 2'b01, 2'b00);
        step(20);

        // Three-cycle glitch on channel 1 must be rejected.
        btn = 2'b10;
        step(3);
        btn = 2'b00;
        step(12);

        // Bounce on channel 0: two-cycle pulses, then a steady press.
        for (int i = 0; i < 6; i++) begin
            btn = (i % 2 == 0) ? 2'b01 : 2'b00;
            step(2);
        end
        btn = 2'b01;
        c = cyc;
        expect_at(c + 6, 2'b01, 2'b01, 2'b00, 2'b00);
        step(8);
        btn = 2'b00;
        c = cyc;
        expect_at(c + 6, 2'b00, 2'b00, 2'b01, 2'b00);
        step(16);

        // Reset while the count sits at 3; a full requalification must follow.
        btn = 2'b01;
        step(5);
        rstn = 1'b0;
        #1;
        check_zero("midcount_reset_outputs");
        step(3);
        rstn = 1'b1;
        c = cyc;
        expect_at(c + 6, 2'b01, 2'b01, 2'b00, 2'b00);
        step(8);
        btn = 2'b00;
        c = cyc;
        expect_at(c + 6, 2'b00, 2'b00, 2'b01, 2'b00);
        step(20);

        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events: got %0d unseen, expected 0 (next due cyc=%0d)",
                     q.size(), q[0].cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
